// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit and the ALU
// control decode that issues operations to it.
package mul_div_unit_pkg;

  localparam int unsigned DATA_W = 32;

  localparam logic MODE_MUL = 1'b0;
  localparam logic MODE_DIV = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    OUT
  } state_e;

endpackage

// File: rtl/mul_div_unit.sv
// Iterative unsigned multiplier (shift-add) / divider (restoring), one
// operation at a time, fixed DATA_W-iteration latency, registered result.
module mul_div_unit
  import mul_div_unit_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid,
  input  logic                  mode,
  input  logic [DATA_W-1:0]     in_A,
  input  logic [DATA_W-1:0]     in_B,
  output logic                  ready,
  output logic [2*DATA_W-1:0]   out
);

  localparam int unsigned        CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DATA_W - 1);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [2*DATA_W-1:0]     shreg_q, shreg_d;
  logic [DATA_W-1:0]       b_q, b_d;
  logic [2*DATA_W-1:0]     out_q, out_d;
  logic                    ready_q, ready_d;

  logic                    alu_sub;
  logic [DATA_W:0]         alu_a, alu_b;
  logic [DATA_W+1:0]       alu_res;
  logic [2*DATA_W-1:0]     shreg_step;

  // Shared 33-bit adder: divide subtracts B from the left-shifted upper half
  // (keeping the bit shifted out of shreg), multiply conditionally adds B.
  // alu_res[DATA_W+1] is the no-borrow flag when subtracting.
  always_comb begin
    alu_sub = (state_q == DIV);
    if (alu_sub) begin
      alu_a = shreg_q[2*DATA_W-1:DATA_W-1];
      alu_b = ~{1'b0, b_q};
    end else begin
      alu_a = {1'b0, shreg_q[2*DATA_W-1:DATA_W]};
      alu_b = shreg_q[0] ? {1'b0, b_q} : '0;
    end
    alu_res = {1'b0, alu_a} + {1'b0, alu_b} + (DATA_W+2)'(alu_sub);

    if (alu_sub) begin
      shreg_step = alu_res[DATA_W+1] ? {alu_res[DATA_W-1:0], shreg_q[DATA_W-2:0], 1'b1}
                                     : {shreg_q[2*DATA_W-2:0], 1'b0};
    end else begin
      shreg_step = {alu_res[DATA_W:0], shreg_q[DATA_W-1:1]};
    end
  end

  // NOTE: every *_d gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    b_d     = b_q;
    out_d   = out_q;
    ready_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (valid) begin
          b_d     = in_B;
          shreg_d = {{DATA_W{1'b0}}, in_A};
          cnt_d   = '0;
          state_d = (mode == MODE_DIV) ? DIV : MUL;
        end
      end
      MUL, DIV: begin
        shreg_d = shreg_step;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = OUT;
          out_d   = shreg_step;
          ready_d = 1'b1;
        end
      end
      OUT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples the
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      b_q     <= '0;
      out_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      b_q     <= b_d;
      out_q   <= out_d;
      ready_q <= ready_d;
    end
  end

  assign out   = out_q;
  assign ready = ready_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit: expected results are queued
// at issue time and compared when the ready strobe appears.
module tb_mul_div_unit;
  import mul_div_unit_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 valid;
  logic                 mode;
  logic [DATA_W-1:0]    in_A;
  logic [DATA_W-1:0]    in_B;
  logic                 ready;
  logic [2*DATA_W-1:0]  out;

  logic [63:0] sb[$];
  int n_cmp = 0;
  int n_err = 0;

  mul_div_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .valid (valid),
    .mode  (mode),
    .in_A  (in_A),
    .in_B  (in_B),
    .ready (ready),
    .out   (out)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no completion, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  // Drive a request at the falling edge; returns just after acceptance edge E0.
  task automatic issue(input logic m, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp, input bit hold);
    @(negedge clk);
    valid = 1'b1;
    mode  = m;
    in_A  = a;
    in_B  = b;
    sb.push_back(exp);
    @(posedge clk);
    #1;
    if (!hold) valid = 1'b0;
  endtask

  // Counts falling edges after E0 until ready; checks latency, value and pulse width.
  task automatic wait_result(input string tag);
    int lat;
    logic [63:0] exp;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (ready === 1'b1) begin
        lat = k;
        break;
      end
    end
    check({tag, " latency"}, 64'(lat), 64'd33);
    exp = (sb.size() > 0) ? sb.pop_front() : 64'hx;
    if (lat != 0) begin
      check({tag, " out"}, out, exp);
      @(negedge clk);
      check({tag, " ready one cycle"}, {63'b0, ready}, 64'd0);
    end
  endtask

  initial begin
    int pulses;
    int pos[$];
    logic [63:0] exp;

    rst_n = 1'b0;
    valid = 1'b0;
    mode  = MODE_MUL;
    in_A  = '0;
    in_B  = '0;
    repeat (2) @(negedge clk);
    check("reset ready", {63'b0, ready}, 64'd0);
    check("reset out", out, 64'd0);
    rst_n = 1'b1;

    issue(MODE_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0);
    wait_result("mul max");

    issue(MODE_DIV, 32'd100, 32'd7, 64'h0000_0002_0000_000E, 1'b0);
    wait_result("div 100/7");

    issue(MODE_DIV, 32'h1234_5678, 32'd0, 64'h1234_5678_FFFF_FFFF, 1'b0);
    wait_result("div by zero");

    issue(MODE_DIV, 32'h8000_0000, 32'd3, {32'd2, 32'h2AAA_AAAA}, 1'b0);
    wait_result("div msb");

    // valid held high while busy; inputs change mid-op and must not be sampled
    issue(MODE_MUL, 32'd3, 32'd5, 64'd15, 1'b1);
    for (int k = 1; k <= 70; k++) begin
      @(negedge clk);
      if (k == 2) begin
        in_A = 32'd9;
        in_B = 32'd9;
      end
      if (k == 34) sb.push_back(64'd81);
      if (k == 35) valid = 1'b0;
      if (ready === 1'b1) begin
        pos.push_back(k);
        exp = (sb.size() > 0) ? sb.pop_front() : 64'hx;
        check("busy out", out, exp);
      end
    end
    check("busy pulse count", 64'(pos.size()), 64'd2);
    if (pos.size() == 2) begin
      check("busy first at", 64'(pos[0]), 64'd33);
      check("busy second at", 64'(pos[1]), 64'd67);
    end
    sb.delete();

    // valid pulsed only during OUT must not start an operation
    issue(MODE_MUL, 32'd2, 32'd3, 64'd6, 1'b0);
    pulses = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (ready === 1'b1) begin
        pulses = k;
        break;
      end
    end
    check("out-state latency", 64'(pulses), 64'd33);
    exp = (sb.size() > 0) ? sb.pop_front() : 64'hx;
    check("out-state result", out, exp);
    valid = 1'b1;
    mode  = MODE_MUL;
    in_A  = 32'd1;
    in_B  = 32'd1;
    @(negedge clk);
    valid = 1'b0;
    pulses = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (ready === 1'b1) pulses++;
    end
    check("out-state ignored pulses", 64'(pulses), 64'd0);
    check("out hold", out, 64'd6);

    // reset during the 10th divide iteration abandons the operation
    @(negedge clk);
    valid = 1'b1;
    mode  = MODE_DIV;
    in_A  = 32'd1000;
    in_B  = 32'd3;
    @(posedge clk);
    #1 valid = 1'b0;
    for (int k = 1; k <= 10; k++) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mid reset ready", {63'b0, ready}, 64'd0);
    check("mid reset out", out, 64'd0);
    pulses = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (ready === 1'b1) pulses++;
    end
    check("mid reset no result", 64'(pulses), 64'd0);

    issue(MODE_MUL, 32'd7, 32'd6, 64'd42, 1'b0);
    wait_result("mul after reset");

    check("scoreboard drained", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
